// File: rtl/midi_voice_alloc_pkg.sv
// -----------------------------------------------------------------------------
// midi_voice_alloc_pkg
// Shared constants and types for the MIDI receive / voice allocation slice.
//   - MIDI channel-message status nibbles used by the parser
//   - parser state encoding
//   - pitch bend centre value
//   - helper deciding which status nibbles open a message on our channel
// Optional feature macro: MIDI_PITCH_BEND_EN (enables the Ex pitch bend message).
// -----------------------------------------------------------------------------
package midi_voice_alloc_pkg;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_CC       = 4'hB;
   localparam logic [3:0] ST_BEND     = 4'hE;

   localparam logic [13:0] PITCH_CENTER = 14'h2000;

`ifdef MIDI_PITCH_BEND_EN
   localparam bit BEND_EN = 1'b1;
`else
   localparam bit BEND_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      P_IDLE  = 2'd0,
      P_DATA1 = 2'd1,
      P_DATA2 = 2'd2
   } parser_state_t;

   // Status nibbles we decode; every other channel message is treated as foreign.
   function automatic logic type_accepted(input logic [3:0] t);
      return (t == ST_NOTE_OFF) || (t == ST_NOTE_ON) || (t == ST_CC) ||
             (BEND_EN && (t == ST_BEND));
   endfunction

endpackage

// File: rtl/midi_voice_alloc_voice_finder.sv
// -----------------------------------------------------------------------------
// voice_finder
// Combinational priority search over the voices: returns the lowest index i
// with en[i]=1 and, when use_key=1, key_tab[i]==key.
// Ports:
//   en       in   VOICES      candidate voices
//   key_tab  in   VOICES*7    stored key per voice, voice i at [i*7 +: 7]
//   key      in   7           key to compare against
//   use_key  in   1           1 = also require key match
//   hit      out  1           some voice qualified
//   idx      out  V_WIDTH     lowest qualifying voice (0 when no hit)
// -----------------------------------------------------------------------------
module voice_finder #(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = 3
) (
   input  logic [VOICES-1:0]   en,
   input  logic [VOICES*7-1:0] key_tab,
   input  logic [6:0]          key,
   input  logic                use_key,
   output logic                hit,
   output logic [V_WIDTH-1:0]  idx
);

   // Scan from the top down so the last assignment is the lowest index.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (en[i] && (!use_key || (key_tab[i*7 +: 7] == key))) begin
            hit = 1'b1;
            idx = V_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/midi_voice_alloc.sv
// -----------------------------------------------------------------------------
// midi_voice_alloc
// MIDI byte-stream receiver for the synth engine. Parses channel messages with
// running status, filters one channel, allocates note-ons to voices (retrigger,
// then lowest free voice, then round-robin steal), releases voices on note-off
// and forwards control changes as a one-cycle write on adr/data.
// Optional feature macro: MIDI_PITCH_BEND_EN -- when defined, Ex messages on
// midi_ch update pitch_val; otherwise Ex is foreign and pitch_val stays centred.
// Ports:
//   sys_clk      in   1        clock, rising edge
//   iRST_N       in   1        asynchronous active-low reset
//   byteready    in   1        midibyte valid strobe
//   midibyte     in   8        received byte
//   midi_ch      in   4        accepted channel
//   voice_free   in   VOICES   envelope idle per voice
//   keys_on      out  VOICES   gate per voice
//   note_on      out  1        STROBE_LEN-cycle pulse per note-on
//   cur_key_adr  out  V_WIDTH  voice of last note event
//   cur_key_val  out  8        key of last note event
//   cur_vel_on   out  8        velocity of last note-on
//   cur_vel_off  out  8        velocity of last note-off
//   write        out  1        CC write strobe
//   adr          out  7        CC number
//   data         out  8        CC value
//   pitch_val    out  14       pitch bend value
// Handshake: byteready is a single-cycle valid with no ready; every strobed
// byte is consumed in the cycle it is presented.
// -----------------------------------------------------------------------------
module midi_voice_alloc
   import midi_voice_alloc_pkg::*;
#(
   parameter int VOICES     = 8,
   parameter int V_WIDTH    = 3,
   parameter int STROBE_LEN = 64
) (
   input  logic               sys_clk,
   input  logic               iRST_N,
   input  logic               byteready,
   input  logic [7:0]         midibyte,
   input  logic [3:0]         midi_ch,
   input  logic [VOICES-1:0]  voice_free,
   output logic [VOICES-1:0]  keys_on,
   output logic               note_on,
   output logic [V_WIDTH-1:0] cur_key_adr,
   output logic [7:0]         cur_key_val,
   output logic [7:0]         cur_vel_on,
   output logic [7:0]         cur_vel_off,
   output logic               write,
   output logic [6:0]         adr,
   output logic [7:0]         data,
   output logic [13:0]        pitch_val
);

   localparam int CNT_W = $clog2(STROBE_LEN + 1);

   // ---------------- parser ----------------
   parser_state_t state, state_nx;
   logic          rs_valid, rs_valid_nx;
   logic [3:0]    rs_type, rs_type_nx;
   logic [6:0]    d1;
   logic          d1_ld, ev_fire;

   logic is_rt, is_sys, is_status;
   assign is_rt     = (midibyte[7:3] == 5'b11111);
   assign is_sys    = (midibyte[7:4] == 4'hF) && !is_rt;
   assign is_status = midibyte[7];

   always_ff @(posedge sys_clk or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= P_IDLE;
         rs_valid <= 1'b0;
         rs_type  <= 4'h0;
         d1       <= 7'h00;
      end else begin
         state    <= state_nx;
         rs_valid <= rs_valid_nx;
         rs_type  <= rs_type_nx;
         if (d1_ld) d1 <= midibyte[6:0];
      end
   end

   always_comb begin
      state_nx    = state;
      rs_valid_nx = rs_valid;
      rs_type_nx  = rs_type;
      d1_ld       = 1'b0;
      ev_fire     = 1'b0;
      if (byteready) begin
         if (is_rt) begin
            // realtime bytes may interleave anywhere; leave the parser untouched
         end else if (is_sys) begin
            rs_valid_nx = 1'b0;
            state_nx    = P_IDLE;
         end else if (is_status) begin
            // channel filter is evaluated here only, so midi_ch changes apply at the next status
            rs_type_nx = midibyte[7:4];
            if ((midibyte[3:0] == midi_ch) && type_accepted(midibyte[7:4])) begin
               rs_valid_nx = 1'b1;
               state_nx    = P_DATA1;
            end else begin
               rs_valid_nx = 1'b0;
               state_nx    = P_IDLE;
            end
         end else begin
            case (state)
               P_IDLE: begin
                  if (rs_valid) begin
                     d1_ld    = 1'b1;
                     state_nx = P_DATA2;
                  end
               end
               P_DATA1: begin
                  d1_ld    = 1'b1;
                  state_nx = P_DATA2;
               end
               P_DATA2: begin
                  ev_fire  = 1'b1;
                  state_nx = P_DATA1;
               end
               default: state_nx = P_IDLE;
            endcase
         end
      end
   end

   // ---------------- event decode ----------------
   logic [6:0] vel;
   logic       ev_on, ev_off, ev_cc;
   assign vel    = midibyte[6:0];
   assign ev_on  = ev_fire && (rs_type == ST_NOTE_ON) && (vel != 7'd0);
   assign ev_off = ev_fire && ((rs_type == ST_NOTE_OFF) ||
                               ((rs_type == ST_NOTE_ON) && (vel == 7'd0)));
   assign ev_cc  = ev_fire && (rs_type == ST_CC);

   // ---------------- voice search ----------------
   logic [VOICES*7-1:0] key_tab;
   logic [V_WIDTH-1:0]  rr_ptr;
   logic                on_hit, free_hit, off_hit;
   logic [V_WIDTH-1:0]  on_idx, free_idx, off_idx, on_v;
   logic                steal;

   voice_finder #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_on_match (
      .en(keys_on), .key_tab(key_tab), .key(d1), .use_key(1'b1),
      .hit(on_hit), .idx(on_idx)
   );

   voice_finder #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_free (
      .en(voice_free & ~keys_on), .key_tab(key_tab), .key(d1), .use_key(1'b0),
      .hit(free_hit), .idx(free_idx)
   );

   voice_finder #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_off_match (
      .en(keys_on), .key_tab(key_tab), .key(d1), .use_key(1'b1),
      .hit(off_hit), .idx(off_idx)
   );

   assign steal = !on_hit && !free_hit;
   assign on_v  = on_hit ? on_idx : (free_hit ? free_idx : rr_ptr);

   // ---------------- registered outputs ----------------
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sys_clk or negedge iRST_N) begin
      if (!iRST_N) begin
         keys_on     <= '0;
         key_tab     <= '0;
         rr_ptr      <= '0;
         note_on     <= 1'b0;
         cnt         <= '0;
         cur_key_adr <= '0;
         cur_key_val <= 8'h00;
         cur_vel_on  <= 8'h00;
         cur_vel_off <= 8'h00;
         write       <= 1'b0;
         adr         <= 7'h00;
         data        <= 8'h00;
      end else begin
         write <= 1'b0;

         // note_on is high for the load cycle plus STROBE_LEN-1 countdown cycles
         if (note_on) begin
            if (cnt == '0) note_on <= 1'b0;
            else           cnt     <= cnt - 1'b1;
         end

         if (ev_on) begin
            keys_on[on_v]            <= 1'b1;
            key_tab[int'(on_v)*7 +: 7] <= d1;
            cur_key_adr              <= on_v;
            cur_key_val              <= {1'b0, d1};
            cur_vel_on               <= {1'b0, vel};
            note_on                  <= 1'b1;
            cnt                      <= CNT_W'(STROBE_LEN - 1);
            if (steal)
               rr_ptr <= (rr_ptr == V_WIDTH'(VOICES - 1)) ? '0 : rr_ptr + 1'b1;
         end

         if (ev_off && off_hit) begin
            keys_on[off_idx] <= 1'b0;
            cur_key_adr      <= off_idx;
            cur_key_val      <= {1'b0, d1};
            cur_vel_off      <= {1'b0, vel};
         end

         if (ev_cc) begin
            write <= 1'b1;
            adr   <= d1;
            data  <= {1'b0, vel};
         end
      end
   end

`ifdef MIDI_PITCH_BEND_EN
   // first data byte is the LSB, second the MSB
   always_ff @(posedge sys_clk or negedge iRST_N) begin
      if (!iRST_N)
         pitch_val <= PITCH_CENTER;
      else if (ev_fire && (rs_type == ST_BEND))
         pitch_val <= {vel, d1};
   end
`else
   assign pitch_val = PITCH_CENTER;
`endif

endmodule

// File: tb/tb_midi_voice_alloc.sv
// -----------------------------------------------------------------------------
// tb_midi_voice_alloc
// Directed bench for midi_voice_alloc: note allocation, running status, voice
// stealing, channel filtering, CC writes, realtime/system byte handling,
// mid-message reset and (with MIDI_PITCH_BEND_EN) pitch bend.
// -----------------------------------------------------------------------------
module tb_midi_voice_alloc;

   logic        sys_clk = 1'b0;
   logic        iRST_N = 1'b0;
   logic        byteready = 1'b0;
   logic [7:0]  midibyte = 8'h00;
   logic [3:0]  midi_ch = 4'h0;
   logic [7:0]  voice_free = 8'hFF;
   logic [7:0]  keys_on;
   logic        note_on;
   logic [2:0]  cur_key_adr;
   logic [7:0]  cur_key_val;
   logic [7:0]  cur_vel_on;
   logic [7:0]  cur_vel_off;
   logic        write;
   logic [6:0]  adr;
   logic [7:0]  data;
   logic [13:0] pitch_val;

   int checks = 0;
   int errors = 0;
   logic [14:0] exp_q[$];   // expected {adr, data} per CC write

   midi_voice_alloc dut (
      .sys_clk(sys_clk), .iRST_N(iRST_N), .byteready(byteready),
      .midibyte(midibyte), .midi_ch(midi_ch), .voice_free(voice_free),
      .keys_on(keys_on), .note_on(note_on), .cur_key_adr(cur_key_adr),
      .cur_key_val(cur_key_val), .cur_vel_on(cur_vel_on),
      .cur_vel_off(cur_vel_off), .write(write), .adr(adr), .data(data),
      .pitch_val(pitch_val)
   );

   // ---------------- clock / reset ----------------
   always #5 sys_clk = ~sys_clk;

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      byteready = 1'b1;
      midibyte  = b;
      @(posedge sys_clk);
      #1;
      byteready = 1'b0;
   endtask

   task automatic do_reset();
      iRST_N = 1'b0;
      idle(2);
      iRST_N = 1'b1;
      idle(1);
   endtask

   // ---------------- CC scoreboard ----------------
   always @(posedge sys_clk) begin
      #1;
      if (write === 1'b1) begin
         if (exp_q.size() == 0)
            chk("cc_unexpected_write", 16'(write), 16'd0);
         else
            chk("cc_write", {1'b0, adr, data}, {1'b0, exp_q.pop_front()});
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      idle(2);
      iRST_N = 1'b1;
      idle(1);

      // reset state
      chk("rst_keys_on", 16'(keys_on), 16'h0);
      chk("rst_note_on", 16'(note_on), 16'h0);
      chk("rst_key_val", 16'(cur_key_val), 16'h0);
      chk("rst_pitch", 16'(pitch_val), 16'h2000);

      // 1: single note-on and strobe length
      send(8'h90); send(8'h3C); send(8'h64);
      chk("t1_keys_on", 16'(keys_on), 16'h01);
      chk("t1_adr", 16'(cur_key_adr), 16'h0);
      chk("t1_key_val", 16'(cur_key_val), 16'h3C);
      chk("t1_vel_on", 16'(cur_vel_on), 16'h64);
      n = 0;
      while (note_on === 1'b1 && n < 200) begin
         n++;
         idle(1);
      end
      chk("t1_note_on_len", 16'(n), 16'd64);

      // 2: running status, velocity-0 note-off, retrigger, 8x off, unmatched off
      do_reset();
      send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
      chk("t2_keys_on", 16'(keys_on), 16'h03);
      chk("t2_adr", 16'(cur_key_adr), 16'h1);
      chk("t2_key_val", 16'(cur_key_val), 16'h40);
      chk("t2_vel_on", 16'(cur_vel_on), 16'h50);
      send(8'h3C); send(8'h00);
      chk("t2_off_keys", 16'(keys_on), 16'h02);
      chk("t2_off_adr", 16'(cur_key_adr), 16'h0);
      chk("t2_off_vel", 16'(cur_vel_off), 16'h00);
      send(8'h40); send(8'h22);
      chk("t2_retrig_keys", 16'(keys_on), 16'h02);
      chk("t2_retrig_adr", 16'(cur_key_adr), 16'h1);
      chk("t2_retrig_vel", 16'(cur_vel_on), 16'h22);
      send(8'h80); send(8'h40); send(8'h11);
      chk("t2_8x_keys", 16'(keys_on), 16'h00);
      chk("t2_8x_vel", 16'(cur_vel_off), 16'h11);
      send(8'h55); send(8'h33);
      chk("t2_nomatch_vel", 16'(cur_vel_off), 16'h11);
      chk("t2_nomatch_key", 16'(cur_key_val), 16'h40);

      // 3: fill all voices, then steal round-robin
      do_reset();
      send(8'h90);
      for (int k = 0; k < 8; k++) begin
         send(8'h30 + 8'(k)); send(8'h40);
      end
      chk("t3_full_keys", 16'(keys_on), 16'hFF);
      chk("t3_full_adr", 16'(cur_key_adr), 16'h7);
      voice_free = 8'h00;
      send(8'h90); send(8'h50); send(8'h7F);
      chk("t3_steal0_adr", 16'(cur_key_adr), 16'h0);
      chk("t3_steal0_key", 16'(cur_key_val), 16'h50);
      chk("t3_steal0_keys", 16'(keys_on), 16'hFF);
      send(8'h51); send(8'h7F);
      chk("t3_steal1_adr", 16'(cur_key_adr), 16'h1);
      voice_free = 8'hFF;

      // 4: foreign channel dropped, CC writes, channel change at next status
      do_reset();
      midi_ch = 4'h0;
      send(8'h91); send(8'h3C); send(8'h64);
      chk("t4_foreign_keys", 16'(keys_on), 16'h00);
      chk("t4_foreign_note", 16'(note_on), 16'h0);
      send(8'hB0); send(8'h07);
      exp_q.push_back({7'h07, 8'h7F});
      send(8'h7F);
      idle(1);
      chk("t4_cc_pulse", 16'(write), 16'h0);
      exp_q.push_back({7'h10, 8'h55});
      send(8'h10); send(8'h55);
      midi_ch = 4'h1;
      exp_q.push_back({7'h20, 8'h33});
      send(8'h20); send(8'h33);
      send(8'hB0); send(8'h21); send(8'h44);   // now foreign
      exp_q.push_back({7'h22, 8'h45});
      send(8'hB1); send(8'h22); send(8'h45);
      idle(2);
      midi_ch = 4'h0;

      // 5: realtime byte ignored mid-message, system byte aborts
      do_reset();
      send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
      chk("t5_rt_keys", 16'(keys_on), 16'h01);
      chk("t5_rt_key", 16'(cur_key_val), 16'h3C);
      send(8'h90); send(8'h3D); send(8'hF0); send(8'h55);
      chk("t5_sys_keys", 16'(keys_on), 16'h01);
      chk("t5_sys_vel", 16'(cur_vel_on), 16'h64);

      // 6: reset mid-message discards the partial message
      do_reset();
      send(8'h90);
      iRST_N = 1'b0;
      idle(1);
      iRST_N = 1'b1;
      idle(1);
      send(8'h3C); send(8'h64);
      chk("t6_keys", 16'(keys_on), 16'h00);
      chk("t6_key_val", 16'(cur_key_val), 16'h00);
      chk("t6_note_on", 16'(note_on), 16'h0);

`ifdef MIDI_PITCH_BEND_EN
      send(8'hE0); send(8'h00); send(8'h40);
      chk("t6_bend_center", 16'(pitch_val), 16'h2000);
      send(8'h7F); send(8'h7F);
      chk("t6_bend_max", 16'(pitch_val), 16'h3FFF);
      send(8'h05); send(8'h21);
      chk("t6_bend_mid", 16'(pitch_val), 16'h1085);
`else
      send(8'hE0); send(8'h7F); send(8'h7F);
      chk("t6_bend_off", 16'(pitch_val), 16'h2000);
      send(8'h3C); send(8'h64);
      chk("t6_bend_drop", 16'(keys_on), 16'h00);
`endif

      idle(2);
      chk("cc_queue_empty", 16'(exp_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
